hsi_encoder: RTL and testbench
==============================

# hsi_encoder

Serial frame encoder for the HSI link: accepts parallel bytes through a valid/ready handshake and drives them onto the single-wire line as start bit, 8 data bits, odd-parity bit and stop bit. Each bit is held for BIT_TICKS `clk_en` ticks. This matches the 8x-oversampling frame format consumed by the HSI decoder at the far end. The block sits directly upstream of the line, between the message source and the decoder input `d`.

## Interface
- BIT_TICKS, 8: `clk_en` ticks per line bit (2..15).
- FIFO_DEPTH, 4: input FIFO entries, power of two; used only with HSI_ENC_FIFO_EN.
- clk  in  1  system clock.
- n_rst  in  1  reset, asynchronous, active-low.
- clk_en  in  1  bit-timing tick; FSM and counters advance only when high.
- d  in  8  byte to transmit.
- d_vld  in  1  `d` valid.
- d_rdy  out  1  block can accept a byte; transfer occurs on any `clk` edge with `d_vld & d_rdy`; not gated by `clk_en`.
- q  out  1  serial line, registered; idle level 1.
- busy  out  1  frame in progress or byte pending.
- frame_done  out  1  one-`clk` pulse on the edge that ends the stop bit.

## Operation
- Frame order: START(0), 8 data bits, parity P, STOP(1); 11 bits total, 11*BIT_TICKS ticks.
- Data order:
  - `` `ML_FST == `LSB `` (from hsi_config.vh): D0 first.
  - Otherwise: D7 first.
  - P is always the last data-phase bit.
- Parity: P = ~(^byte), so data plus P holds an odd number of ones.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions happen on `clk` edges with `clk_en`=1.
  - IDLE -> START when a byte is pending. The byte is popped into the shift register on that edge.
  - START -> DATA after BIT_TICKS ticks.
  - DATA -> PARITY after 8 bits, tracked by bit_idx 0..7.
  - PARITY -> STOP after BIT_TICKS ticks.
  - STOP -> START directly if a byte is pending (no idle gap); otherwise STOP -> IDLE.
- Bit timer tick_cnt (4 bits): counts 0..BIT_TICKS-1, wraps to 0 on each bit boundary, and is cleared in IDLE.
- `q` is registered from the state and shift register. It changes only on bit boundaries and stays 1 in IDLE and STOP.
- Outputs:
  - busy = (state != IDLE) | pending.
  - frame_done fires on the STOP-exit edge, whether the next state is START or IDLE.
- `clk_en`=0: FSM, tick_cnt, bit_idx and `q` are frozen. Handshake loads still occur.

## Timing
- Reset values: q=1, d_rdy=1, busy=0, frame_done=0, state=IDLE, storage empty.
- Latency: a byte accepted at edge N while IDLE drives `q`=0 from the first `clk_en` edge after N. A push and an IDLE pop never occur on the same edge.
- Bit duration is exactly BIT_TICKS `clk_en` ticks. Example: with `clk_en` every 4th `clk`, BIT_TICKS=8 gives 32 `clk` per bit.
- Back-to-back frames: the next START bit begins on the tick right after the last STOP tick. Line period = 11*BIT_TICKS ticks.
- Simultaneous push and pop on one edge: both take effect; occupancy is unchanged.
- Reset mid-frame: `q` returns to 1 asynchronously, pending bytes are discarded, and no frame_done is issued.

## Configuration
- HSI_ENC_FIFO_EN defined:
  - Storage is a FIFO of FIFO_DEPTH entries.
  - d_rdy = ~full.
  - Bytes are transmitted strictly in acceptance order.
- HSI_ENC_FIFO_EN undefined:
  - Storage is a single holding register and FIFO_DEPTH is ignored.
  - d_rdy = ~hold_vld.
  - The holding register refills while the shift register transmits, so back-to-back frames are still possible.

## Test plan
- Push 0xA5, `ML_FST`=LSB, `clk_en`=1 -> `q` sequence 0,1,0,1,0,0,1,0,1,1(P),1(stop), each bit 8 `clk` long; one frame_done pulse; busy falls on the same edge.
- Push 0x01 with `clk_en` asserted every 4th `clk` -> P=0, each bit 32 `clk`, frame lasts 352 `clk`.
- Loopback `q` into the HSI decoder, send 0x00, 0xFF, 0x5A, 0x81 back-to-back -> decoder outputs q_rdy with matching bytes, pb_err never asserted, no idle bits between frames.
- Hold `d_vld`=1 continuously with the macro defined, FIFO_DEPTH=4 -> d_rdy drops after 5 accepts (4 in FIFO plus 1 in shift register) and reasserts on each STOP->START pop.
- Assert n_rst during DATA bit 3 of 0xC3 -> `q`=1 immediately, busy=0, no frame_done; the next pushed byte is transmitted as a complete, correct frame.
- Hold `clk_en`=0 for 50 `clk` mid-PARITY -> `q` and tick_cnt frozen; the frame resumes with the remaining ticks intact.

Source files
------------

// File: rtl/hsi_encoder.sv
// rtl/hsi_encoder.sv - HSI serial frame encoder: start, 8 data bits, odd parity, stop
//
// Parameters:
//   BIT_TICKS   clk_en ticks per line bit (2..15)
//   FIFO_DEPTH  input FIFO entries, power of two >= 2 (used only with HSI_ENC_FIFO_EN)
// Ports:
//   clk         system clock
//   n_rst       asynchronous active-low reset
//   clk_en      bit-timing tick; FSM, bit timer and q advance only when high
//   d/d_vld     byte to transmit and its valid
//   d_rdy       storage can take a byte; loads happen on any clk edge (not gated by clk_en)
//   q           registered serial line, idles at 1
//   busy        frame in progress or byte pending
//   frame_done  one-clk pulse after the edge that ends a stop bit
// Build option:
//   HSI_ENC_FIFO_EN  defined: FIFO_DEPTH-entry input FIFO; undefined: single holding register
// Bit order follows `ML_FST / `LSB (hsi_config.vh); LSB-first when those are not provided.

`ifndef LSB
`define LSB 0
`endif
`ifndef MSB
`define MSB 1
`endif
`ifndef ML_FST
`define ML_FST `LSB
`endif

module hsi_encoder #(
  parameter int BIT_TICKS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clk_en,
  input  logic [7:0] d,
  input  logic       d_vld,
  output logic       d_rdy,
  output logic       q,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] TICK_LAST = 4'(BIT_TICKS - 1);
  localparam bit         LSB_FIRST = (`ML_FST == `LSB);

  if (BIT_TICKS < 2 || BIT_TICKS > 15 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("hsi_encoder: BIT_TICKS must be 2..15 and FIFO_DEPTH a power of two >= 2");
  end

  state_t     state, state_nx;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic [7:0] head;
  logic       pending;
  logic       push;
  logic       pop;
  logic       boundary;

  function automatic logic line_bit(input logic [7:0] b, input logic [2:0] idx);
    return LSB_FIRST ? b[idx] : b[3'd7 - idx];
  endfunction

  assign push = d_vld & d_rdy;

`ifdef HSI_ENC_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign pending = (count != '0);
  assign d_rdy   = (count != (AW + 1)'(FIFO_DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end
`else
  logic       hold_vld;
  logic [7:0] hold_data;

  assign pending = hold_vld;
  assign d_rdy   = ~hold_vld;
  assign head    = hold_data;

  // Push needs hold_vld=0 and pop needs hold_vld=1, so they never coincide.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
    end else if (push) begin
      hold_vld  <= 1'b1;
      hold_data <= d;
    end else if (pop) begin
      hold_vld  <= 1'b0;
    end
  end
`endif

  assign boundary = clk_en && (tick_cnt == TICK_LAST);
  assign busy     = (state != IDLE) | pending;

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (clk_en && pending) begin
          state_nx = START;
          pop      = 1'b1;
        end
      end
      START:  if (boundary) state_nx = DATA;
      DATA:   if (boundary && bit_idx == 3'd7) state_nx = PARITY;
      PARITY: if (boundary) state_nx = STOP;
      STOP: begin
        if (boundary) begin
          if (pending) begin
            state_nx = START;
            pop      = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // q is loaded with the value of the bit that starts on this edge, so the
  // line changes exactly on bit boundaries (or on the pop edge for START).
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      q          <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == STOP) && boundary;
      state      <= state_nx;
      if (clk_en) begin
        tick_cnt <= (state == IDLE || boundary) ? 4'd0 : tick_cnt + 4'd1;
        if (state == DATA && boundary) bit_idx <= bit_idx + 3'd1;
        if (pop) begin
          shreg <= head;
          q     <= 1'b0;
        end else if (boundary) begin
          case (state)
            START:   q <= line_bit(shreg, 3'd0);
            DATA:    q <= (bit_idx == 3'd7) ? ~(^shreg) : line_bit(shreg, bit_idx + 3'd1);
            default: q <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_hsi_encoder.sv
// tb/tb_hsi_encoder.sv - randomized bench for hsi_encoder against a per-tick line model

`ifndef LSB
`define LSB 0
`endif
`ifndef MSB
`define MSB 1
`endif
`ifndef ML_FST
`define ML_FST `LSB
`endif

module tb_hsi_encoder;

  localparam int BT    = 8;
  localparam int DEPTH = 4;
`ifdef HSI_ENC_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif
  localparam bit LSB_FIRST = (`ML_FST == `LSB);

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       clk_en = 1'b1;
  logic [7:0] d = '0;
  logic       d_vld = 1'b0;
  logic       d_rdy;
  logic       q;
  logic       busy;
  logic       frame_done;

  hsi_encoder #(.BIT_TICKS(BT), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .clk_en     (clk_en),
    .d          (d),
    .d_vld      (d_vld),
    .d_rdy      (d_rdy),
    .q          (q),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Model: bytes waiting in storage, and the line level for every upcoming tick.
  logic [7:0] pend_q[$];
  bit         line_q[$];
  bit         exp_fd;
  bit         accepted;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         fd_count = 0;
  int         en_mode = 0;  // 0: always, 1: every 4th clk, 2: random, 3: held low
  bit         trace_q[0:511];
  bit         trace_fd[0:511];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic void append_frame(input logic [7:0] b);
    bit bits[11];
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i + 1] = LSB_FIRST ? b[i] : b[7 - i];
    bits[9]  = ~(^b);
    bits[10] = 1'b1;
    for (int k = 0; k < 11; k++)
      for (int t = 0; t < BT; t++) line_q.push_back(bits[k]);
  endfunction

  task automatic model_edge();
    bit rdy_pre;
    rdy_pre  = (pend_q.size() < CAP);
    exp_fd   = 1'b0;
    accepted = 1'b0;
    if (!n_rst) begin
      pend_q.delete();
      line_q.delete();
      return;
    end
    if (clk_en) begin
      if (line_q.size() > 0) begin
        line_q.delete(0);
        if (line_q.size() == 0) exp_fd = 1'b1;
      end
      if (line_q.size() == 0 && pend_q.size() > 0) append_frame(pend_q.pop_front());
    end
    if (d_vld && rdy_pre) begin
      pend_q.push_back(d);
      accepted = 1'b1;
    end
  endtask

  task automatic next_en();
    case (en_mode)
      0:       clk_en = 1'b1;
      1:       clk_en = (cyc % 4 == 0);
      2:       clk_en = ($urandom_range(0, 2) != 0);
      default: clk_en = 1'b0;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("q", q, (line_q.size() > 0) ? line_q[0] : 1'b1);
    check_eq("busy", busy, (line_q.size() > 0 || pend_q.size() > 0));
    check_eq("frame_done", frame_done, exp_fd);
    check_eq("d_rdy", d_rdy, (pend_q.size() < CAP));
    if (frame_done) fd_count++;
    cyc++;
    next_en();
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    d = b;
    d_vld = 1'b1;
    do begin
      step();
      n++;
    end while (!accepted && n < 400);
    check_eq("send_accepted", accepted, 1'b1);
    d_vld = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_mode(input int m);
    en_mode = m;
    next_en();
  endtask

  initial begin
    int fd0;
    int t_low;
    int t_fd;
    int accepts;
    bit exp_a5[11];

    // Reset state
    n_rst = 1'b0;
    @(negedge clk);
    check_eq("rst_q", q, 1'b1);
    check_eq("rst_d_rdy", d_rdy, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_frame_done", frame_done, 1'b0);
    run(3);
    n_rst = 1'b1;
    run(2);

    // 0xA5, clk_en always high: fixed line pattern, 8 clk per bit
    exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    fd0 = fd_count;
    send(8'hA5);
    for (int i = 1; i <= 100; i++) begin
      step();
      trace_q[i]  = q;
      trace_fd[i] = frame_done;
    end
    for (int k = 0; k < 11; k++) begin
      check_eq("a5_bit_head", trace_q[k * BT + 1], exp_a5[k]);
      check_eq("a5_bit_tail", trace_q[k * BT + BT], exp_a5[k]);
    end
    check_eq("a5_done_slot", trace_fd[11 * BT + 1], 1'b1);
    check_eq("a5_done_count", fd_count - fd0, 1);

    // 0x01 with clk_en every 4th clk: frame lasts 11*8*4 clk
    set_mode(1);
    fd0 = fd_count;
    t_low = -1;
    t_fd = -1;
    send(8'h01);
    for (int i = 0; i < 420; i++) begin
      step();
      if (!q && t_low < 0) t_low = i;
      if (frame_done && t_fd < 0) t_fd = i;
    end
    check_eq("x01_frame_clks", t_fd - t_low, 352);
    check_eq("x01_done_count", fd_count - fd0, 1);

    // Back-to-back frames
    set_mode(0);
    fd0 = fd_count;
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    send(8'h81);
    run(4 * 11 * BT);
    check_eq("b2b_done_count", fd_count - fd0, 4);

`ifdef HSI_ENC_FIFO_EN
    // Continuous d_vld: DEPTH entries plus one in the shift register
    accepts = 0;
    d = 8'h3C;
    d_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (d_rdy) accepts++;
      else break;
      step();
      d = d + 8'd1;
    end
    d_vld = 1'b0;
    check_eq("fifo_accepts", accepts, DEPTH + 1);
    run(6 * 11 * BT);
`else
    accepts = 0;
`endif

    // Reset during DATA bit 3 of 0xC3
    fd0 = fd_count;
    send(8'hC3);
    run(BT * 4 + 3);
    #2 n_rst = 1'b0;
    #1;
    check_eq("midrst_q", q, 1'b1);
    check_eq("midrst_busy", busy, 1'b0);
    pend_q.delete();
    line_q.delete();
    run(2);
    n_rst = 1'b1;
    run(2);
    check_eq("midrst_no_done", fd_count - fd0, 0);
    send(8'h3C);
    run(11 * BT + 10);
    check_eq("postrst_done_count", fd_count - fd0, 1);

    // clk_en held low for 50 clk in the middle of PARITY
    send(8'h96);
    run(9 * BT + 3);
    set_mode(3);
    run(50);
    set_mode(0);
    run(2 * BT + 10);

    // Randomized traffic and clk_en
    set_mode(2);
    for (int i = 0; i < 3000; i++) begin
      d_vld = ($urandom_range(0, 1) == 1);
      d = 8'($urandom);
      step();
    end
    d_vld = 1'b0;
    set_mode(0);
    run((CAP + 1) * 11 * BT + 20);
    check_eq("drain_idle", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
